// File: rtl/l1_mau_arb_if.sv
// Wishbone B4 pipelined bus between the L1 miss arbiter and the memory slave.
interface l1_mau_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_W-1:0]     wb_adr_o;
  logic [DATA_W-1:0]     wb_dat_o;
  logic [DATA_W/8-1:0]   wb_sel_o;
  logic [DATA_W-1:0]     wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_stall_i;
  logic                  wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_stall_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_stall_i, wb_err_i
  );
endinterface

// File: rtl/l1_mau_arb.sv
// L1I/L1D miss arbiter: round-robin grant, one outstanding Wishbone
// pipelined burst (line read) or single-beat word write at a time.
module l1_mau_arb #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         l1i_req_val,
  input  logic [ADDR_W-1:0]            l1i_req_addr,
  output logic                         l1i_req_ack,
  output logic [LINE_WORDS*DATA_W-1:0] l1i_ack_data,
  input  logic                         l1d_req_val,
  input  logic                         l1d_req_we,
  input  logic [ADDR_W-1:0]            l1d_req_addr,
  input  logic [DATA_W-1:0]            l1d_req_wdata,
  input  logic [DATA_W/8-1:0]          l1d_req_be,
  output logic                         l1d_req_ack,
  output logic [LINE_WORDS*DATA_W-1:0] l1d_ack_data,
  l1_mau_arb_if.master                 wb
);

  localparam int unsigned BYTES_W  = DATA_W / 8;
  localparam int unsigned LINE_OFF = $clog2(LINE_WORDS * BYTES_W);
  localparam int unsigned WORD_OFF = $clog2(BYTES_W);
  localparam int unsigned CNT_W    = $clog2(LINE_WORDS) + 1;

  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << LINE_OFF;
  localparam logic [ADDR_W-1:0] WORD_MASK = {ADDR_W{1'b1}} << WORD_OFF;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t                         r_state;
  state_t                         w_next;

  logic                           r_gnt_d;     // 1: transaction in flight belongs to L1D
  logic                           r_last_d;    // 1: most recent grant went to L1D
  logic                           r_we;
  logic [ADDR_W-1:0]              r_adr;
  logic [DATA_W-1:0]              r_wdata;
  logic [BYTES_W-1:0]             r_sel;
  logic [CNT_W-1:0]               r_iss_cnt;
  logic [CNT_W-1:0]               r_ack_cnt;
  logic [LINE_WORDS*DATA_W-1:0]   r_line;

  logic                           w_gnt_any;
  logic                           w_gnt_d;
  logic [ADDR_W-1:0]              w_req_addr;
  logic                           w_req_we;
  logic                           w_grant;
  logic                           w_cyc;
  logic                           w_accept;
  logic                           w_ack_in;
  logic [CNT_W-1:0]               w_last_idx;
  logic                           w_last_iss;
  logic                           w_last_ack;

  // Round-robin pick between the two requesters and selection of their request fields
  always_comb begin
    w_gnt_any  = l1i_req_val | l1d_req_val;
    w_gnt_d    = 1'b0;
    if (l1i_req_val && l1d_req_val) begin
      w_gnt_d = ~r_last_d;
    end else begin
      w_gnt_d = l1d_req_val;
    end
    w_req_addr = w_gnt_d ? l1d_req_addr : l1i_req_addr;
    w_req_we   = w_gnt_d & l1d_req_we;
  end

  // Bus handshake qualifiers; acks are only counted while the cycle is open
  always_comb begin
    w_grant    = (r_state == IDLE) && w_gnt_any;
    w_cyc      = (r_state == ISSUE) || (r_state == DRAIN);
    w_accept   = (r_state == ISSUE) && !wb.wb_stall_i;
    w_last_idx = r_we ? '0 : LAST_BEAT;
    w_ack_in   = w_cyc && (wb.wb_ack_i || wb.wb_err_i) && (r_ack_cnt <= w_last_idx);
    w_last_iss = w_accept && (r_iss_cnt == w_last_idx);
    w_last_ack = w_ack_in && (r_ack_cnt == w_last_idx);
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_gnt_any) w_next = ISSUE;
      // With a same-cycle acking slave the final ack lands together with the
      // final accept, so DRAIN is skipped to keep the minimum latency.
      ISSUE: if (w_last_iss) w_next = w_last_ack ? RESP : DRAIN;
      DRAIN: if (w_last_ack) w_next = RESP;
      RESP:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request capture on grant, beat address/issue counter, ack counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_d   <= 1'b0;
      r_last_d  <= 1'b1;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdata   <= '0;
      r_sel     <= '0;
      r_iss_cnt <= '0;
      r_ack_cnt <= '0;
    end else if (w_grant) begin
      r_gnt_d   <= w_gnt_d;
      r_last_d  <= w_gnt_d;
      r_we      <= w_req_we;
      r_adr     <= w_req_we ? (w_req_addr & WORD_MASK) : (w_req_addr & LINE_MASK);
      r_wdata   <= l1d_req_wdata;
      r_sel     <= w_req_we ? l1d_req_be : '1;
      r_iss_cnt <= '0;
      r_ack_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_adr     <= r_adr + ADDR_W'(BYTES_W);
        r_iss_cnt <= r_iss_cnt + CNT_W'(1);
      end
      if (w_ack_in) begin
        r_ack_cnt <= r_ack_cnt + CNT_W'(1);
      end
    end
  end

  // Line assembly: k-th read ack fills slot k, an error ack fills it with zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
    end else if (w_ack_in && !r_we) begin
      for (int unsigned k = 0; k < LINE_WORDS; k++) begin
        if (r_ack_cnt == CNT_W'(k)) begin
          r_line[k*DATA_W +: DATA_W] <= wb.wb_err_i ? '0 : wb.wb_dat_i;
        end
      end
    end
  end

  assign wb.wb_cyc_o  = w_cyc;
  assign wb.wb_stb_o  = (r_state == ISSUE);
  assign wb.wb_we_o   = r_we;
  assign wb.wb_adr_o  = r_adr;
  assign wb.wb_dat_o  = r_wdata;
  assign wb.wb_sel_o  = r_sel;

  assign l1i_req_ack  = (r_state == RESP) && !r_gnt_d;
  assign l1d_req_ack  = (r_state == RESP) &&  r_gnt_d;
  assign l1i_ack_data = r_line;
  assign l1d_ack_data = r_line;

endmodule

// File: tb/tb_l1_mau_arb.sv
// Scoreboard bench for l1_mau_arb with a configurable Wishbone slave.
module tb_l1_mau_arb;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LW         = LINE_WORDS * DATA_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          l1i_req_val = 1'b0;
  logic [31:0]   l1i_req_addr = '0;
  logic          l1i_req_ack;
  logic [LW-1:0] l1i_ack_data;
  logic          l1d_req_val = 1'b0;
  logic          l1d_req_we = 1'b0;
  logic [31:0]   l1d_req_addr = '0;
  logic [31:0]   l1d_req_wdata = '0;
  logic [3:0]    l1d_req_be = '0;
  logic          l1d_req_ack;
  logic [LW-1:0] l1d_ack_data;

  l1_mau_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wbs ();

  l1_mau_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .l1i_req_val(l1i_req_val), .l1i_req_addr(l1i_req_addr),
    .l1i_req_ack(l1i_req_ack), .l1i_ack_data(l1i_ack_data),
    .l1d_req_val(l1d_req_val), .l1d_req_we(l1d_req_we),
    .l1d_req_addr(l1d_req_addr), .l1d_req_wdata(l1d_req_wdata),
    .l1d_req_be(l1d_req_be), .l1d_req_ack(l1d_req_ack),
    .l1d_ack_data(l1d_ack_data), .wb(wbs)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat; } beat_t;
  typedef struct { logic is_d; logic [LW-1:0] line; } resp_t;
  typedef struct { int due; logic err; logic [31:0] dat; } pend_t;

  beat_t exp_beats[$];
  resp_t exp_resp[$];
  pend_t pend[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;
  int last_ack_cyc = 0;

  // slave configuration and bookkeeping
  int stall_beat = -1;
  int stall_left = 0;
  int ack_dly = 0;
  int err_beat = -1;
  int acc_idx = 0;
  int tot_acc = 0;
  int tot_ack = 0;
  logic prev_stall = 1'b0;
  logic [31:0] stall_adr = '0;
  logic [LW-1:0] model_line = '0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [31:0] slv_dat(input logic [31:0] a);
    return 32'hA0 + 32'(a[3:2]) + (((a >> 4) ^ 32'h10) << 8);
  endfunction

  function automatic logic [LW-1:0] exp_line(input logic [31:0] base, input int err_k);
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < int'(LINE_WORDS); k++)
      if (k != err_k) l[k*32 +: 32] = slv_dat(base + 32'(k*4));
    return l;
  endfunction

  task automatic push_read(input logic is_d, input logic [31:0] addr, input int err_k);
    logic [31:0] base;
    base = addr & ~32'hF;
    for (int k = 0; k < int'(LINE_WORDS); k++)
      exp_beats.push_back('{base + 32'(k*4), 1'b0, 4'hF, 32'h0});
    model_line = exp_line(base, err_k);
    exp_resp.push_back('{is_d, model_line});
  endtask

  // Wishbone slave model plus requester-ack monitor, evaluated on the falling edge
  initial begin
    beat_t b;
    resp_t r;
    pend_t p;
    logic [LW-1:0] got;
    wbs.wb_ack_i = 1'b0; wbs.wb_err_i = 1'b0; wbs.wb_stall_i = 1'b0; wbs.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (l1i_req_ack || l1d_req_ack) begin
        last_ack_cyc = cyc_n;
        vectors++;
        if (l1i_req_ack && l1d_req_ack) begin
          miscompares++;
          $display("FAIL dual_ack got i=1 d=1 required one");
        end else if (exp_resp.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_ack got i=%0b d=%0b required none", l1i_req_ack, l1d_req_ack);
        end else begin
          r = exp_resp.pop_front();
          if (l1d_req_ack !== r.is_d) begin
            miscompares++;
            $display("FAIL ack_owner got d=%0b required d=%0b", l1d_req_ack, r.is_d);
          end
          got = l1d_req_ack ? l1d_ack_data : l1i_ack_data;
          vectors++;
          if (got !== r.line) begin
            miscompares++;
            $display("FAIL ack_line got %h required %h", got, r.line);
          end
        end
      end

      wbs.wb_ack_i = 1'b0; wbs.wb_err_i = 1'b0; wbs.wb_stall_i = 1'b0; wbs.wb_dat_i = '0;
      if (!wbs.wb_cyc_o) acc_idx = 0;
      if (wbs.wb_cyc_o && wbs.wb_stb_o) begin
        if (prev_stall) begin
          vectors++;
          if (wbs.wb_adr_o !== stall_adr) begin
            miscompares++;
            $display("FAIL stall_adr_hold got %h required %h", wbs.wb_adr_o, stall_adr);
          end
        end
        if (stall_beat >= 0 && acc_idx == stall_beat && stall_left > 0) begin
          wbs.wb_stall_i = 1'b1;
          stall_left--;
          prev_stall = 1'b1;
          stall_adr = wbs.wb_adr_o;
        end else begin
          prev_stall = 1'b0;
          vectors++;
          if (exp_beats.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_beat got adr=%h required none", wbs.wb_adr_o);
          end else begin
            b = exp_beats.pop_front();
            if ({wbs.wb_adr_o, wbs.wb_we_o, wbs.wb_sel_o} !== {b.adr, b.we, b.sel}) begin
              miscompares++;
              $display("FAIL beat got adr=%h we=%0b sel=%h required adr=%h we=%0b sel=%h",
                       wbs.wb_adr_o, wbs.wb_we_o, wbs.wb_sel_o, b.adr, b.we, b.sel);
            end
            if (b.we) begin
              vectors++;
              if (wbs.wb_dat_o !== b.dat) begin
                miscompares++;
                $display("FAIL beat_wdata got %h required %h", wbs.wb_dat_o, b.dat);
              end
            end
          end
          pend.push_back('{cyc_n + ack_dly, (err_beat >= 0 && acc_idx == err_beat), slv_dat(wbs.wb_adr_o)});
          acc_idx++;
          tot_acc++;
        end
      end else if (prev_stall) begin
        prev_stall = 1'b0;
        vectors++;
        miscompares++;
        $display("FAIL stall_stb_hold got stb=%0b cyc=%0b required 1 1", wbs.wb_stb_o, wbs.wb_cyc_o);
      end
      if (pend.size() > 0 && pend[0].due == cyc_n) begin
        p = pend.pop_front();
        if (p.err) wbs.wb_err_i = 1'b1; else wbs.wb_ack_i = 1'b1;
        wbs.wb_dat_i = p.err ? 32'hBAD0BAD0 : p.dat;
        tot_ack++;
      end
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_resp.size() != 0 || exp_beats.size() != 0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    vectors++;
    if (exp_resp.size() != 0 || exp_beats.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout got resp=%0d beats=%0d pending required 0 0",
               name, exp_resp.size(), exp_beats.size());
      exp_resp.delete();
      exp_beats.delete();
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({wbs.wb_cyc_o, wbs.wb_stb_o, wbs.wb_we_o, l1i_req_ack, l1d_req_ack} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b required 00000",
               {wbs.wb_cyc_o, wbs.wb_stb_o, wbs.wb_we_o, l1i_req_ack, l1d_req_ack});
    end
    vectors++;
    if ({wbs.wb_adr_o, wbs.wb_dat_o, wbs.wb_sel_o} !== 68'h0) begin
      miscompares++;
      $display("FAIL reset_bus got adr=%h dat=%h sel=%h required 0",
               wbs.wb_adr_o, wbs.wb_dat_o, wbs.wb_sel_o);
    end
    vectors++;
    if (l1i_ack_data !== '0 || l1d_ack_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data got i=%h d=%h required 0", l1i_ack_data, l1d_ack_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    push_read(1'b0, 32'h300, -1);
    push_read(1'b1, 32'h400, -1);
    push_read(1'b0, 32'h340, -1);
    l1i_req_addr = 32'h300;
    l1d_req_addr = 32'h400;
    l1d_req_we = 1'b0;
    l1i_req_val = 1'b1;
    l1d_req_val = 1'b1;
    @(posedge clk); #1;
    l1i_req_addr = 32'h340;
    n = 0;
    while (exp_resp.size() != 0 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    l1i_req_val = 1'b0;
    l1d_req_val = 1'b0;
    wait_done("b2b", 10);
  endtask

  task automatic test_l1i_read();
    int g;
    ack_dly = 0;
    for (int k = 0; k < 4; k++)
      exp_beats.push_back('{32'h100 + 32'(k*4), 1'b0, 4'hF, 32'h0});
    model_line = 128'h000000A3_000000A2_000000A1_000000A0;
    exp_resp.push_back('{1'b0, model_line});
    l1i_req_addr = 32'h104;
    l1i_req_val = 1'b1;
    @(posedge clk); #1;
    g = cyc_n;
    l1i_req_val = 1'b0;
    l1i_req_addr = 32'hFFFF_FFFF;
    wait_done("l1i_read", 20);
    vectors++;
    if (last_ack_cyc - g != int'(LINE_WORDS)) begin
      miscompares++;
      $display("FAIL l1i_latency got %0d required %0d", last_ack_cyc - g, LINE_WORDS);
    end
    vectors++;
    if (l1i_req_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL l1i_ack_pulse got %0b required 0", l1i_req_ack);
    end
  endtask

  task automatic test_l1d_write();
    exp_beats.push_back('{32'h20, 1'b1, 4'h3, 32'hDEADBEEF});
    exp_resp.push_back('{1'b1, model_line});
    l1d_req_addr = 32'h20;
    l1d_req_we = 1'b1;
    l1d_req_wdata = 32'hDEADBEEF;
    l1d_req_be = 4'h3;
    l1d_req_val = 1'b1;
    @(posedge clk); #1;
    l1d_req_val = 1'b0;
    l1d_req_we = 1'b0;
    l1d_req_wdata = 32'h12345678;
    l1d_req_be = 4'hC;
    l1d_req_addr = 32'h44;
    wait_done("l1d_write", 20);
    vectors++;
    if (l1d_req_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL l1d_ack_pulse got %0b required 0", l1d_req_ack);
    end
  endtask

  task automatic test_stall();
    int a0, k0;
    ack_dly = 3;
    stall_beat = 1;
    stall_left = 2;
    a0 = tot_acc;
    k0 = tot_ack;
    push_read(1'b1, 32'h508, -1);
    l1d_req_addr = 32'h508;
    l1d_req_we = 1'b0;
    l1d_req_val = 1'b1;
    @(posedge clk); #1;
    l1d_req_val = 1'b0;
    wait_done("stall", 40);
    vectors++;
    if (tot_acc - a0 != 4) begin
      miscompares++;
      $display("FAIL stall_accepts got %0d required 4", tot_acc - a0);
    end
    vectors++;
    if (tot_ack - k0 != 4) begin
      miscompares++;
      $display("FAIL stall_acks got %0d required 4", tot_ack - k0);
    end
    stall_beat = -1;
    ack_dly = 0;
  endtask

  task automatic test_error();
    ack_dly = 1;
    err_beat = 2;
    push_read(1'b0, 32'h600, 2);
    l1i_req_addr = 32'h600;
    l1i_req_val = 1'b1;
    @(posedge clk); #1;
    l1i_req_val = 1'b0;
    wait_done("error", 30);
    err_beat = -1;
    ack_dly = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    ack_dly = 3;
    for (int k = 0; k < 4; k++)
      exp_beats.push_back('{32'h700 + 32'(k*4), 1'b0, 4'hF, 32'h0});
    l1i_req_addr = 32'h700;
    l1i_req_val = 1'b1;
    @(posedge clk); #1;
    l1i_req_val = 1'b0;
    n = 0;
    while (acc_idx < 2 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    vectors++;
    if (acc_idx < 2) begin
      miscompares++;
      $display("FAIL mid_reset_wait got beats=%0d required 2", acc_idx);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({wbs.wb_cyc_o, wbs.wb_stb_o, l1i_req_ack, l1d_req_ack} !== 4'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got %b required 0000",
               {wbs.wb_cyc_o, wbs.wb_stb_o, l1i_req_ack, l1d_req_ack});
    end
    pend.delete();
    exp_beats.delete();
    exp_resp.delete();
    model_line = '0;
    ack_dly = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_read(1'b1, 32'h800, -1);
    l1d_req_addr = 32'h800;
    l1d_req_we = 1'b0;
    l1d_req_val = 1'b1;
    @(posedge clk); #1;
    l1d_req_val = 1'b0;
    wait_done("post_reset", 20);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_l1i_read();
    test_l1d_write();
    test_stall();
    test_error();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog got timeout required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/l1_mau_arb.md
L1_MAU_ARB -- requirements
Module: l1_mau_arb

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 32, address width.
- DATA_W, 32, bus word width.
- LINE_WORDS, 4, words per cache line (power of 2, 2..16).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- l1i_req_val, in, 1, L1I line-fill request.
- l1i_req_addr, in, ADDR_W, L1I byte address.
- l1i_req_ack, out, 1, L1I completion pulse.
- l1i_ack_data, out, LINE_WORDS*DATA_W, L1I fill line.
- l1d_req_val, in, 1, L1D request.
- l1d_req_we, in, 1, 1=word write, 0=line read.
- l1d_req_addr, in, ADDR_W, L1D byte address.
- l1d_req_wdata, in, DATA_W, write word.
- l1d_req_be, in, DATA_W/8, write byte enables.
- l1d_req_ack, out, 1, L1D completion pulse.
- l1d_ack_data, out, LINE_WORDS*DATA_W, L1D read line.
- wb_cyc_o / wb_stb_o / wb_we_o, out, 1 each, Wishbone B4 pipelined master controls.
- wb_adr_o, out, ADDR_W, beat address.
- wb_dat_o, out, DATA_W, write data.
- wb_sel_o, out, DATA_W/8, byte select.
- wb_dat_i, in, DATA_W, read data.
- wb_ack_i / wb_stall_i / wb_err_i, in, 1 each, slave responses.

Function
REQ-003 FSM states: IDLE, ISSUE, DRAIN, RESP; IDLE->ISSUE on grant; ISSUE->DRAIN after last stb accepted; DRAIN->RESP when ack count equals beat count; RESP->IDLE after one cycle.
REQ-004 Arbitration in IDLE: round-robin; if only one val is high, that requester wins; if both are high, the requester not granted last wins; the first grant after reset goes to L1I.
REQ-005 Requester inputs SHALL be sampled into registers on the grant cycle; later changes, including val deassertion, do not affect the transaction in flight.
REQ-006 Reads SHALL issue LINE_WORDS beats at base = addr with its low log2(LINE_WORDS*DATA_W/8) bits cleared; beat k address = base + k*DATA_W/8; wb_sel_o all ones; wb_we_o=0.
REQ-007 L1D write SHALL issue exactly one beat: wb_adr_o = addr with the low 2 bits cleared, wb_dat_o = wdata, wb_sel_o = be, wb_we_o=1.
REQ-008 wb_cyc_o SHALL be high from the first cycle of ISSUE through the cycle of the final ack, inclusive, and low otherwise.
REQ-009 Bus handshake: a beat is accepted when wb_stb_o=1 and wb_stall_i=0; the address advances only on acceptance; wb_adr_o, wb_stb_o and wb_sel_o hold steady while stalled.
REQ-010 Acks may arrive in the same cycle as stb, or later; the ack counter is independent of the issue counter; acks received while cyc=0 are ignored.
REQ-011 The k-th ack SHALL write wb_dat_i into line bits [k*DATA_W +: DATA_W]; wb_err_i counts as an ack and writes 0 into that slot.
REQ-012 In RESP, the ack of the granted requester SHALL pulse high for exactly one cycle with the line valid; line registers hold until the next capture; write acks return the data registers unchanged.
REQ-013 Minimum latency, for a zero-stall slave acking in the same cycle: grant cycle plus LINE_WORDS issue cycles plus 1 RESP cycle; the next grant is possible in the cycle after RESP.
REQ-014 A single outstanding transaction at a time; a requester whose val is high during RESP competes in the following IDLE cycle.

Reset
REQ-015 On rst_n low, all outputs SHALL go to 0 asynchronously, the FSM to IDLE, the counters to 0, and the last-grant pointer to L1D so that L1I wins first; a reset mid-transaction abandons the bus cycle (cyc drops) with no ack.

Verification
REQ-016 L1I read 0x104, zero-stall slave returning 0xA0+k -> beats at 0x100, 0x104, 0x108, 0x10C; l1i_ack_data = {0xA3,0xA2,0xA1,0xA0}; ack pulses for 1 cycle.
REQ-017 L1D write 0x20 with data 0xDEADBEEF and be=0x3 -> one beat: we=1, sel=0x3, adr 0x20; l1d_req_ack pulses once.
REQ-018 L1I and L1D val high together for 3 back-to-back transactions -> grant order L1I, L1D, L1I.
REQ-019 wb_stall_i high for 2 cycles on beat 1, acks delayed 3 cycles -> adr stable while stalled; exactly 4 stb accepts and 4 acks; correct data ordering.
REQ-020 wb_err_i on beat 2 -> slot 2 = 0; transaction completes with ack.
REQ-021 rst_n low in the cycle after beat 1 is issued -> cyc, stb and acks go to 0 immediately; after release, a new L1D request completes normally.
